// File: rtl/yuv422_to_rgb.sv
// Packed 4-pixel YUV422 to RGB888 converter (BT.601 full range), four-stage pipeline.
// All state updates on the falling clock edge; clip_count_o counts output beats with clamping.
module yuv422_to_rgb #(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned CLIP_CNT_W = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [63:0]           yuv_i,
   input  logic                  yuv_valid_i,
   input  logic                  clip_clr_i,
   output logic [95:0]           rgb_o,
   output logic                  rgb_valid_o,
   output logic [CLIP_CNT_W-1:0] clip_count_o
);

   // S1: luma and centred chroma
   logic        [7:0]  y1_d  [4];
   logic        [7:0]  y1_q  [4];
   logic signed [8:0]  ud1_d [2];
   logic signed [8:0]  ud1_q [2];
   logic signed [8:0]  vd1_d [2];
   logic signed [8:0]  vd1_q [2];
   // S2: products
   logic        [7:0]  y2_q  [4];
   logic signed [17:0] ud_x  [2];
   logic signed [17:0] vd_x  [2];
   logic signed [17:0] prv_d [2];
   logic signed [17:0] prv_q [2];
   logic signed [17:0] pgu_d [2];
   logic signed [17:0] pgu_q [2];
   logic signed [17:0] pgv_d [2];
   logic signed [17:0] pgv_q [2];
   logic signed [17:0] pbu_d [2];
   logic signed [17:0] pbu_q [2];
   // S3: unclamped channel values
   logic signed [11:0] r3_d  [4];
   logic signed [11:0] r3_q  [4];
   logic signed [11:0] g3_d  [4];
   logic signed [11:0] g3_q  [4];
   logic signed [11:0] b3_d  [4];
   logic signed [11:0] b3_q  [4];
   // S4: clamp and output
   logic [8:0]            cr [4];
   logic [8:0]            cg [4];
   logic [8:0]            cb [4];
   logic [95:0]           rgb_new;
   logic                  clip_any;
   logic [95:0]           rgb_d, rgb_q;
   logic [LATENCY-1:0]    vld_d, vld_q;
   logic [CLIP_CNT_W-1:0] cnt_d, cnt_q;
   logic                  out_load;

   function automatic logic signed [11:0] add_off(input logic [7:0] y,
                                                   input logic signed [17:0] acc);
      logic signed [17:0] off;
      logic signed [17:0] tot;
      off = (acc + 18'sd128) >>> 8;
      tot = signed'({10'b0, y}) + off;
      return tot[11:0];
   endfunction

   // {clipped, value}
   function automatic logic [8:0] clamp(input logic signed [11:0] v);
      if (v[11]) begin
         return {1'b1, 8'h00};
      end else if (v[10:8] != 3'b000) begin
         return {1'b1, 8'hFF};
      end
      return {1'b0, v[7:0]};
   endfunction

   always_comb begin
      y1_d[0]  = yuv_i[63:56];
      y1_d[1]  = yuv_i[47:40];
      y1_d[2]  = yuv_i[31:24];
      y1_d[3]  = yuv_i[15:8];
      ud1_d[0] = {1'b0, yuv_i[55:48]} - 9'd128;
      vd1_d[0] = {1'b0, yuv_i[39:32]} - 9'd128;
      ud1_d[1] = {1'b0, yuv_i[23:16]} - 9'd128;
      vd1_d[1] = {1'b0, yuv_i[7:0]} - 9'd128;
   end

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         ud_x[c]  = {{9{ud1_q[c][8]}}, ud1_q[c]};
         vd_x[c]  = {{9{vd1_q[c][8]}}, vd1_q[c]};
         prv_d[c] = 18'sd359 * vd_x[c];
         pgu_d[c] = -18'sd88 * ud_x[c];
         pgv_d[c] = 18'sd183 * vd_x[c];
         pbu_d[c] = 18'sd454 * ud_x[c];
      end
   end

   // Pixels 0,1 share chroma pair 0; pixels 2,3 share pair 1
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         r3_d[p] = add_off(y2_q[p], prv_q[p/2]);
         g3_d[p] = add_off(y2_q[p], pgu_q[p/2] - pgv_q[p/2]);
         b3_d[p] = add_off(y2_q[p], pbu_q[p/2]);
      end
   end

   always_comb begin
      clip_any = 1'b0;
      rgb_new  = '0;
      for (int p = 0; p < 4; p++) begin
         cr[p] = clamp(r3_q[p]);
         cg[p] = clamp(g3_q[p]);
         cb[p] = clamp(b3_q[p]);
         rgb_new[95-24*p -: 24] = {cr[p][7:0], cg[p][7:0], cb[p][7:0]};
         clip_any = clip_any | cr[p][8] | cg[p][8] | cb[p][8];
      end
   end

   assign out_load = vld_q[LATENCY-2];

   always_comb begin
      vld_d = {vld_q[LATENCY-2:0], yuv_valid_i};
      rgb_d = out_load ? rgb_new : rgb_q;
      cnt_d = cnt_q;
      if (clip_clr_i) begin
         cnt_d = '0;
      end else if (out_load && clip_any && (cnt_q != '1)) begin
         cnt_d = cnt_q + {{(CLIP_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(negedge clk_i) begin
      if (reset_i) begin
         vld_q <= '0;
         rgb_q <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         rgb_q <= rgb_d;
         cnt_q <= cnt_d;
      end
   end

   // Data stages need no reset: validity is tracked by vld_q alone
   always_ff @(negedge clk_i) begin
      y1_q  <= y1_d;
      ud1_q <= ud1_d;
      vd1_q <= vd1_d;
      y2_q  <= y1_q;
      prv_q <= prv_d;
      pgu_q <= pgu_d;
      pgv_q <= pgv_d;
      pbu_q <= pbu_d;
      r3_q  <= r3_d;
      g3_q  <= g3_d;
      b3_q  <= b3_d;
   end

   assign rgb_o        = rgb_q;
   assign rgb_valid_o  = vld_q[LATENCY-1];
   assign clip_count_o = cnt_q;

endmodule
